// File: rtl/clock_rate_detector.sv
// rtl/clock_rate_detector.sv - measures a divided clock's period in sys_clk cycles and decodes its divider tap
module clock_rate_detector #(
  parameter int              CNT_W       = 33,
  parameter int              LOCK_N      = 3,
  parameter longint unsigned TIMEOUT_CYC = (64'd1 << CNT_W) - 64'd1
) (
  input  logic             sys_clk,
  input  logic             rst,
  input  logic             en,
  input  logic             clk_in,
  output logic [CNT_W-1:0] period,
  output logic [4:0]       tap,
  output logic             valid,
  output logic             locked,
  output logic             err,
  output logic             timeout
);

  localparam int              LC_W   = $clog2(LOCK_N) + 1;
  localparam logic [CNT_W-1:0] TO_LIM = TIMEOUT_CYC[CNT_W-1:0];
  localparam logic [CNT_W-1:0] ONE    = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [LC_W-1:0]  LC_MAX = LC_W'(LOCK_N - 1);
  localparam logic [LC_W-1:0]  LC_ONE = {{(LC_W-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {IDLE, ARM, MEAS} state_t;

  state_t           state_q, state_d;
  logic             s1, s2, s3;
  logic             e;
  logic [CNT_W-1:0] cnt, cnt_d, cnt_inc;
  logic [LC_W-1:0]  lc, lc_d, lc_n;
  logic [CNT_W-1:0] period_d;
  logic [4:0]       tap_d;
  logic             valid_d, locked_d, err_d, timeout_d;
  logic             pow2;
  logic [6:0]       idx;

  assign e = s2 & ~s3;

  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      s1      <= 1'b0;
      s2      <= 1'b0;
      s3      <= 1'b0;
      state_q <= IDLE;
      cnt     <= '0;
      lc      <= '0;
      period  <= '0;
      tap     <= '0;
      valid   <= 1'b0;
      locked  <= 1'b0;
      err     <= 1'b0;
      timeout <= 1'b0;
    end else begin
      s1      <= clk_in;
      s2      <= s1;
      s3      <= s2;
      state_q <= state_d;
      cnt     <= cnt_d;
      lc      <= lc_d;
      period  <= period_d;
      tap     <= tap_d;
      valid   <= valid_d;
      locked  <= locked_d;
      err     <= err_d;
      timeout <= timeout_d;
    end
  end

  // A valid rate is a single set bit at position >= 1; its index minus one is the tap.
  always_comb begin
    idx = '0;
    for (int i = 0; i < CNT_W; i++) begin
      if (cnt[i]) idx = 7'(i);
    end
    pow2 = ((cnt & (cnt - ONE)) == '0) && (cnt[CNT_W-1:1] != '0);
  end

  always_comb begin
    state_d   = state_q;
    cnt_inc   = (cnt == '1) ? cnt : cnt + ONE;
    cnt_d     = cnt;
    lc_d      = lc;
    lc_n      = (lc == LC_MAX) ? lc : lc + LC_ONE;
    period_d  = period;
    tap_d     = tap;
    valid_d   = 1'b0;
    locked_d  = locked;
    err_d     = err;
    timeout_d = timeout;
    if (!en) begin
      state_d   = IDLE;
      cnt_d     = '0;
      lc_d      = '0;
      locked_d  = 1'b0;
      timeout_d = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          cnt_d     = ONE;
          locked_d  = 1'b0;
          timeout_d = 1'b0;
          state_d   = ARM;
        end
        ARM: begin
          if (e) begin
            cnt_d     = ONE;
            timeout_d = 1'b0;
            state_d   = MEAS;
          end else if (cnt == TO_LIM) begin
            cnt_d     = ONE;
            lc_d      = '0;
            locked_d  = 1'b0;
            timeout_d = 1'b1;
          end else begin
            cnt_d = cnt_inc;
          end
        end
        MEAS: begin
          if (e) begin
            period_d  = cnt;
            valid_d   = 1'b1;
            cnt_d     = ONE;
            timeout_d = 1'b0;
            if (!pow2) begin
              err_d    = 1'b1;
              lc_d     = '0;
              locked_d = 1'b0;
            end else begin
              err_d = 1'b0;
              tap_d = 5'(idx - 7'd1);
              // The previous period, even one left over from before a clear, is the reference.
              if (cnt == period) begin
                lc_d     = lc_n;
                locked_d = (lc_n == LC_MAX);
              end else begin
                lc_d     = '0;
                locked_d = (LC_MAX == '0);
              end
            end
          end else if (cnt == TO_LIM) begin
            cnt_d     = ONE;
            lc_d      = '0;
            locked_d  = 1'b0;
            timeout_d = 1'b1;
            state_d   = ARM;
          end else begin
            cnt_d = cnt_inc;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_clock_rate_detector.sv
// tb/tb_clock_rate_detector.sv - scoreboard bench for clock_rate_detector
module tb_clock_rate_detector;

  localparam int CNT_W  = 33;
  localparam int LOCK_N = 3;
  localparam int TO     = 100;

  logic             sys_clk;
  logic             rst;
  logic             en;
  logic             clk_in;
  logic [CNT_W-1:0] period;
  logic [4:0]       tap;
  logic             valid;
  logic             locked;
  logic             err;
  logic             timeout;

  clock_rate_detector #(
    .CNT_W       (CNT_W),
    .LOCK_N      (LOCK_N),
    .TIMEOUT_CYC (64'(TO))
  ) dut (
    .sys_clk (sys_clk),
    .rst     (rst),
    .en      (en),
    .clk_in  (clk_in),
    .period  (period),
    .tap     (tap),
    .valid   (valid),
    .locked  (locked),
    .err     (err),
    .timeout (timeout)
  );

  typedef struct {
    longint per;
    longint tp;
    longint er;
    longint lk;
  } exp_t;

  exp_t   exp_q[$];
  longint hist[$];
  int     checks   = 0;
  int     failures = 0;
  int     cyc      = 0;
  bit     have_prev;
  int     prev_rise;
  longint last_p;
  bit     last_err;
  longint exp_tap;

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;
  always @(posedge sys_clk) cyc <= cyc + 1;

  task automatic chk(input string name, input longint act, input longint req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  // Lock history: run of identical good periods; a clear keeps the held period as the reference.
  task automatic model_clear();
    have_prev = 1'b0;
    hist = {};
    if (!last_err && last_p != 0) hist.push_back(last_p);
  endtask

  task automatic model_period(input longint p);
    exp_t x;
    bit   good;
    good = (p >= 2) && ((p & (p - 1)) == 0);
    if (good) exp_tap = $clog2(p) - 1;
    if (!good) hist = {};
    else if (hist.size() > 0 && hist[$] != p) hist = {p};
    else hist.push_back(p);
    x.per = p;
    x.tp  = exp_tap;
    x.er  = good ? 0 : 1;
    x.lk  = (hist.size() >= LOCK_N) ? 1 : 0;
    last_p   = p;
    last_err = !good;
    exp_q.push_back(x);
  endtask

  task automatic model_rise();
    int gap;
    if (!en) return;
    gap = cyc - prev_rise;
    if (have_prev) begin
      if (gap > TO) model_clear();
      else model_period(longint'(gap));
    end
    have_prev = 1'b1;
    prev_rise = cyc;
  endtask

  task automatic drive(input logic v);
    @(posedge sys_clk);
    #1;
    if (v && !clk_in) model_rise();
    clk_in = v;
  endtask

  task automatic wave(input int h, input int l, input int n);
    for (int k = 0; k < n; k++) begin
      repeat (h) drive(1'b1);
      repeat (l) drive(1'b0);
    end
  endtask

  task automatic to_cyc(input int t);
    while (cyc < t) begin
      @(posedge sys_clk);
      #2;
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(posedge sys_clk);
      n++;
    end
    @(posedge sys_clk);
    #1;
    chk("drain", longint'(exp_q.size()), 0);
  endtask

  initial begin : monitor
    exp_t x;
    forever begin
      @(negedge sys_clk);
      if (!rst && valid) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_valid", 1, 0);
        end else begin
          x = exp_q.pop_front();
          chk("period", longint'(period), x.per);
          chk("tap", longint'(tap), x.tp);
          chk("err", longint'(err), x.er);
          chk("locked", longint'(locked), x.lk);
        end
      end
    end
  end

  initial begin : stim
    int c;
    int r;
    rst = 1'b1;
    en = 1'b0;
    clk_in = 1'b0;
    have_prev = 1'b0;
    prev_rise = 0;
    last_p = 0;
    last_err = 1'b0;
    exp_tap = 0;
    repeat (2) @(negedge sys_clk);
    chk("rst_period", longint'(period), 0);
    chk("rst_tap", longint'(tap), 0);
    chk("rst_valid", longint'(valid), 0);
    chk("rst_locked", longint'(locked), 0);
    chk("rst_err", longint'(err), 0);
    chk("rst_timeout", longint'(timeout), 0);
    rst = 1'b0;
    en = 1'b1;
    repeat (4) drive(1'b0);

    wave(1, 1, 8);
    wave(16, 16, 25);
    wave(4, 4, 6);
    wave(5, 7, 3);
    wave(16, 16, 5);

    c = prev_rise;
    to_cyc(c + 102);
    chk("to_pre_timeout", longint'(timeout), 0);
    chk("to_pre_locked", longint'(locked), 1);
    to_cyc(c + 103);
    chk("to_timeout", longint'(timeout), 1);
    chk("to_locked", longint'(locked), 0);
    chk("to_period_hold", longint'(period), last_p);
    to_cyc(c + 110);
    drive(1'b1);
    c = cyc;
    to_cyc(c + 2);
    chk("to_hold_until_e", longint'(timeout), 1);
    to_cyc(c + 3);
    chk("to_clear_on_e", longint'(timeout), 0);
    repeat (12) drive(1'b1);
    repeat (16) drive(1'b0);
    wave(16, 16, 4);

    drain();
    chk("en_pre_locked", longint'(locked), 1);
    en = 1'b0;
    model_clear();
    c = cyc;
    to_cyc(c + 1);
    chk("en_low_locked", longint'(locked), 0);
    chk("en_low_period", longint'(period), last_p);
    wave(4, 4, 4);
    repeat (6) drive(1'b0);
    en = 1'b1;
    wave(2, 2, 6);

    drain();
    chk("rst_mid_locked_before", longint'(locked), 1);
    #2;
    rst = 1'b1;
    #1;
    chk("rst_mid_period", longint'(period), 0);
    chk("rst_mid_locked", longint'(locked), 0);
    chk("rst_mid_tap", longint'(tap), 0);
    rst = 1'b0;
    have_prev = 1'b0;
    hist = {};
    last_p = 0;
    last_err = 1'b0;
    exp_tap = 0;
    repeat (4) drive(1'b0);
    wave(1, 1, 6);

    for (int s = 0; s < 8; s++) begin
      r = int'($urandom_range(0, 4));
      if (r == 0) begin
        wave(int'($urandom_range(1, 30)), int'($urandom_range(1, 30)), int'($urandom_range(2, 5)));
      end else begin
        c = 1 << $urandom_range(0, 5);
        wave(c, c, int'($urandom_range(2, 5)));
      end
    end

    drain();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
